// File: rtl/difftest_trace_checker.sv
// Lock-step commit checker against a reference model, with a trace ring
// that is dumped oldest-first after the first divergence.
module difftest_trace_checker #(
   parameter int XLEN        = 64,
   parameter int NCOMMIT     = 2,
   parameter int TRACE_DEPTH = 64,
   parameter int TIMEOUT     = 4096
) (
   input  logic                    clk_i,
   input  logic                    arst_i,
   input  logic [NCOMMIT-1:0]      commit_valid_i,
   input  logic [NCOMMIT-1:0]      commit_trap_i,
   input  logic [NCOMMIT*XLEN-1:0] commit_pc_i,
   input  logic [NCOMMIT*XLEN-1:0] commit_wdata_i,
   output logic                    step_valid_o,
   output logic [3:0]              step_num_o,
   input  logic [XLEN-1:0]         ref_pc_i,
   input  logic [XLEN-1:0]         ref_wdata_i,
   output logic                    err_o,
   output logic [2:0]              err_code_o,
   output logic [63:0]             commit_cnt_o,
   output logic                    dump_valid_o,
   input  logic                    dump_ready_i,
   output logic                    dump_last_o,
   output logic [XLEN-1:0]         dump_pc_o,
   output logic                    dump_trap_o,
   output logic                    done_o
);
   localparam int AW = $clog2(TRACE_DEPTH);
   localparam int FW = AW + 1;
   localparam int IW = $clog2(TIMEOUT + 1);

   typedef enum logic [1:0] {RUN, DUMP, DONE} state_t;
   state_t state;

   logic [NCOMMIT-1:0] cv;
   logic [3:0]         pop;
   logic [AW-1:0]      wr_idx [NCOMMIT];
   logic [XLEN-1:0]    young_pc, young_wdata;
   logic               young_trap;

   logic [AW-1:0]      wr_ptr, rd_ptr;
   logic [FW-1:0]      fill, fill_nxt, dump_left;
   logic [FW+3:0]      fill_sum;
   logic [IW-1:0]      idle_cnt;
   logic               idle_armed;

   logic               vld_p1, cmp_trap_p1;
   logic [XLEN-1:0]    cmp_pc_p1, cmp_wdata_p1;

   logic [XLEN:0]      trace_mem [TRACE_DEPTH];

   logic               cmp_act, err_hit;
   logic [2:0]         err_nxt;

   function automatic logic [FW-1:0] sat_fill(input logic [FW+3:0] s);
      return (s > (FW+4)'(TRACE_DEPTH)) ? FW'(TRACE_DEPTH) : s[FW-1:0];
   endfunction

   // p0: commits are only honoured in RUN; channel order fixes ring slots
   always_comb begin
      cv          = (state == RUN) ? commit_valid_i : '0;
      pop         = '0;
      young_pc    = '0;
      young_wdata = '0;
      young_trap  = 1'b0;
      for (int k = 0; k < NCOMMIT; k++) begin
         wr_idx[k] = wr_ptr + AW'(pop);
         if (cv[k]) begin
            pop         = pop + 4'd1;
            young_pc    = commit_pc_i[k*XLEN +: XLEN];
            young_wdata = commit_wdata_i[k*XLEN +: XLEN];
            young_trap  = commit_trap_i[k];
         end
      end
      fill_sum = (FW+4)'(fill) + (FW+4)'(pop);
      fill_nxt = sat_fill(fill_sum);
   end

   assign step_valid_o = |cv;
   assign step_num_o   = pop;

   // p1: compare last cycle's youngest commit against the reference
   always_comb begin
      cmp_act = (state == RUN) && vld_p1 && !cmp_trap_p1;
      err_hit = 1'b0;
      err_nxt = 3'd0;
      if (cmp_act && $isunknown({ref_pc_i, ref_wdata_i, cmp_pc_p1, cmp_wdata_p1})) begin
         err_hit = 1'b1;
         err_nxt = 3'd4;
      end else if (cmp_act && (cmp_pc_p1 != ref_pc_i)) begin
         err_hit = 1'b1;
         err_nxt = 3'd1;
      end else if (cmp_act && (cmp_wdata_p1 != ref_wdata_i)) begin
         err_hit = 1'b1;
         err_nxt = 3'd2;
      end else if ((state == RUN) && idle_armed && (pop == 4'd0) &&
                   (idle_cnt == IW'(TIMEOUT - 1))) begin
         err_hit = 1'b1;
         err_nxt = 3'd3;
      end
   end

   always_ff @(posedge clk_i) begin
      for (int k = 0; k < NCOMMIT; k++)
         if (cv[k]) trace_mem[wr_idx[k]] <= {commit_pc_i[k*XLEN +: XLEN], commit_trap_i[k]};
   end

   always_ff @(posedge clk_i or negedge arst_i) begin
      if (!arst_i) begin
         state        <= RUN;
         wr_ptr       <= '0;
         rd_ptr       <= '0;
         fill         <= '0;
         dump_left    <= '0;
         idle_cnt     <= '0;
         idle_armed   <= 1'b0;
         vld_p1       <= 1'b0;
         cmp_trap_p1  <= 1'b0;
         cmp_pc_p1    <= '0;
         cmp_wdata_p1 <= '0;
         commit_cnt_o <= '0;
         err_o        <= 1'b0;
         err_code_o   <= '0;
      end else begin
         vld_p1       <= |cv;
         cmp_trap_p1  <= young_trap;
         cmp_pc_p1    <= young_pc;
         cmp_wdata_p1 <= young_wdata;
         if (state == RUN) begin
            wr_ptr       <= wr_ptr + AW'(pop);
            fill         <= fill_nxt;
            commit_cnt_o <= commit_cnt_o + 64'(pop);
            if (pop != 4'd0) begin
               idle_cnt   <= '0;
               idle_armed <= 1'b1;
            end else if (idle_armed && (idle_cnt != IW'(TIMEOUT))) begin
               idle_cnt <= idle_cnt + IW'(1);
            end
            if (err_hit) begin
               err_o      <= 1'b1;
               err_code_o <= err_nxt;
               // oldest entry sits fill slots behind the post-write pointer
               rd_ptr     <= (wr_ptr + AW'(pop)) - fill_nxt[AW-1:0];
               dump_left  <= fill_nxt;
               state      <= (fill_nxt == '0) ? DONE : DUMP;
            end
         end else if (state == DUMP) begin
            if (dump_ready_i) begin
               rd_ptr    <= rd_ptr + AW'(1);
               dump_left <= dump_left - FW'(1);
               if (dump_left == FW'(1)) state <= DONE;
            end
         end
      end
   end

   assign dump_valid_o = (state == DUMP);
   assign dump_last_o  = (state == DUMP) && (dump_left == FW'(1));
   assign dump_pc_o    = dump_valid_o ? trace_mem[rd_ptr][XLEN:1] : '0;
   assign dump_trap_o  = dump_valid_o && trace_mem[rd_ptr][0];
   assign done_o       = (state == DONE);

endmodule

// File: tb/tb_difftest_trace_checker.sv
// Scoreboard bench for difftest_trace_checker: directed commit/reference
// sequences, expected errors, dump beats and halts queued for a monitor.
module tb_difftest_trace_checker;
   logic         clk = 1'b0;
   logic         arst_i = 1'b0;
   logic [1:0]   cv = '0, ct = '0;
   logic [127:0] cpc = '0, cwd = '0;
   logic [63:0]  rpc = '0, rwd = '0;
   logic         dump_ready = 1'b1;
   logic         step_valid, err, dump_valid, dump_last, dump_trap, done;
   logic [3:0]   step_num;
   logic [2:0]   err_code;
   logic [63:0]  cnt, dump_pc;

   always #5 clk = ~clk;

   difftest_trace_checker #(.XLEN(64), .NCOMMIT(2), .TRACE_DEPTH(4), .TIMEOUT(16)) dut (
      .clk_i(clk), .arst_i(arst_i), .commit_valid_i(cv), .commit_trap_i(ct),
      .commit_pc_i(cpc), .commit_wdata_i(cwd), .step_valid_o(step_valid),
      .step_num_o(step_num), .ref_pc_i(rpc), .ref_wdata_i(rwd), .err_o(err),
      .err_code_o(err_code), .commit_cnt_o(cnt), .dump_valid_o(dump_valid),
      .dump_ready_i(dump_ready), .dump_last_o(dump_last), .dump_pc_o(dump_pc),
      .dump_trap_o(dump_trap), .done_o(done)
   );

   typedef struct packed {logic [63:0] pc; logic trap; logic last;} beat_t;
   beat_t      exp_dump[$];
   logic [2:0] exp_err[$];
   int         exp_done[$];
   int         total = 0, bad = 0;
   logic       err_prev = 1'b0, done_prev = 1'b0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
      total++;
      if (act !== req) begin
         bad++;
         $display("FAIL %s actual=0x%0h required=0x%0h", name, act, req);
      end
   endtask

   // monitor: pops an expectation whenever the DUT presents an event
   always @(negedge clk) begin
      if (arst_i) begin
         if (dump_valid && dump_ready) begin
            if (exp_dump.size() == 0) begin
               total++; bad++;
               $display("FAIL dump_extra actual=beat pc 0x%0h required=no beat", dump_pc);
            end else begin
               check("dump_pc", dump_pc, exp_dump[0].pc);
               check("dump_trap", {63'd0, dump_trap}, {63'd0, exp_dump[0].trap});
               check("dump_last", {63'd0, dump_last}, {63'd0, exp_dump[0].last});
               void'(exp_dump.pop_front());
            end
         end
         if (err && !err_prev) begin
            if (exp_err.size() == 0) begin
               total++; bad++;
               $display("FAIL err_extra actual=code %0d required=no error", err_code);
            end else begin
               check("err_code", {61'd0, err_code}, {61'd0, exp_err[0]});
               void'(exp_err.pop_front());
            end
         end
         if (done && !done_prev) begin
            if (exp_done.size() == 0) begin
               total++; bad++;
               $display("FAIL done_extra actual=done required=running");
            end else begin
               void'(exp_done.pop_front());
            end
         end
      end
      err_prev  <= err;
      done_prev <= done;
   end

   task automatic drive(input logic [1:0] v, input logic [1:0] t, input logic [63:0] p0,
                        input logic [63:0] p1, input logic [63:0] w0, input logic [63:0] w1);
      cv = v; ct = t; cpc = {p1, p0}; cwd = {w1, w0};
   endtask

   task automatic idle_in();
      cv = '0; ct = '0;
   endtask

   task automatic to_pos();
      @(posedge clk); #1;
   endtask

   task automatic do_reset();
      idle_in(); rpc = '0; rwd = '0;
      #2 arst_i = 1'b0; #2;
      check("rst_err", {63'd0, err}, 64'd0);
      check("rst_code", {61'd0, err_code}, 64'd0);
      check("rst_cnt", cnt, 64'd0);
      check("rst_dump_valid", {63'd0, dump_valid}, 64'd0);
      check("rst_done", {63'd0, done}, 64'd0);
      @(negedge clk); arst_i = 1'b1;
      to_pos();
   endtask

   task automatic wait_done(input int budget, input string name);
      int n = 0;
      while (!done && n < budget) begin
         @(negedge clk); n++;
      end
      check(name, {63'd0, done}, 64'd1);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog actual=timeout required=finish");
      $fatal(1, "watchdog");
   end

   logic [63:0] xprobe;
   logic [2:0]  x_code;

   initial begin
      xprobe = 'x;
      x_code = $isunknown(xprobe) ? 3'd4 : 3'd1;

      // dual commit that matches the reference
      do_reset();
      drive(2'b11, 2'b00, 64'h8000_0000, 64'h8000_0004, 64'h11, 64'h22);
      @(negedge clk);
      check("t1_step_valid", {63'd0, step_valid}, 64'd1);
      check("t1_step_num", {60'd0, step_num}, 64'd2);
      to_pos(); idle_in(); rpc = 64'h8000_0004; rwd = 64'h22;
      @(negedge clk);
      check("t1_step_idle", {60'd0, step_num}, 64'd0);
      check("t1_cnt", cnt, 64'd2);
      to_pos();
      @(negedge clk);
      check("t1_no_err", {63'd0, err}, 64'd0);

      // PC mismatch, then a two-entry dump
      do_reset();
      drive(2'b01, 2'b00, 64'h8000_0008, 64'h0, 64'h1, 64'h0);
      to_pos(); drive(2'b01, 2'b00, 64'h8000_0010, 64'h0, 64'h5, 64'h0);
      rpc = 64'h8000_0008; rwd = 64'h1;
      @(negedge clk);
      check("t2_err_first", {63'd0, err}, 64'd0);
      to_pos(); idle_in(); rpc = 64'h8000_0014; rwd = 64'h5;
      exp_err.push_back(3'd1);
      exp_dump.push_back({64'h8000_0008, 1'b0, 1'b0});
      exp_dump.push_back({64'h8000_0010, 1'b0, 1'b1});
      exp_done.push_back(2);
      @(negedge clk);
      check("t2_err_before", {63'd0, err}, 64'd0);
      to_pos();
      @(negedge clk);
      check("t2_err_after", {63'd0, err}, 64'd1);
      check("t2_code", {61'd0, err_code}, 64'd1);
      wait_done(10, "t2_done");

      // trapped commit skips the compare
      do_reset();
      drive(2'b01, 2'b01, 64'h100, 64'h0, 64'hAA, 64'h0);
      to_pos(); idle_in(); rpc = 64'h999; rwd = 64'hBB;
      @(negedge clk);
      check("t3_cnt", cnt, 64'd1);
      to_pos();
      @(negedge clk);
      check("t3_no_err", {63'd0, err}, 64'd0);

      // ring wrap: only the newest four entries are dumped
      do_reset();
      for (int i = 0; i < 7; i++) begin
         drive(2'b01, 2'b00, 64'(4 * i), 64'h0, 64'(i), 64'h0);
         if (i > 0) begin
            rpc = 64'(4 * (i - 1)); rwd = 64'(i - 1);
         end
         to_pos();
      end
      idle_in(); rpc = 64'h1C; rwd = 64'd6;
      exp_err.push_back(3'd1);
      exp_dump.push_back({64'hC, 1'b0, 1'b0});
      exp_dump.push_back({64'h10, 1'b0, 1'b0});
      exp_dump.push_back({64'h14, 1'b0, 1'b0});
      exp_dump.push_back({64'h18, 1'b0, 1'b1});
      exp_done.push_back(4);
      @(negedge clk);
      check("t4_cnt", cnt, 64'd7);
      wait_done(20, "t4_done");

      // timeout and dump stall
      do_reset();
      dump_ready = 1'b0;
      drive(2'b01, 2'b00, 64'h40, 64'h0, 64'h3, 64'h0);
      to_pos(); idle_in(); rpc = 64'h40; rwd = 64'h3;
      exp_err.push_back(3'd3);
      repeat (15) to_pos();
      @(negedge clk);
      check("t5_err_early", {63'd0, err}, 64'd0);
      to_pos();
      @(negedge clk);
      check("t5_err_at16", {63'd0, err}, 64'd1);
      check("t5_code", {61'd0, err_code}, 64'd3);
      for (int i = 0; i < 5; i++) begin
         to_pos();
         @(negedge clk);
         check("t5_hold_valid", {63'd0, dump_valid}, 64'd1);
         check("t5_hold_pc", dump_pc, 64'h40);
         check("t5_hold_last", {63'd0, dump_last}, 64'd1);
         check("t5_hold_done", {63'd0, done}, 64'd0);
      end
      exp_dump.push_back({64'h40, 1'b0, 1'b1});
      exp_done.push_back(5);
      to_pos(); dump_ready = 1'b1;
      wait_done(5, "t5_done");

      // wdata mismatch on a trapped-free commit
      do_reset();
      drive(2'b01, 2'b00, 64'h300, 64'h0, 64'h1, 64'h0);
      to_pos(); idle_in(); rpc = 64'h300; rwd = 64'h2;
      exp_err.push_back(3'd2);
      exp_dump.push_back({64'h300, 1'b0, 1'b1});
      exp_done.push_back(6);
      wait_done(8, "t6_done");

      // unknown reference with PC mismatch, then reset mid-dump
      do_reset();
      dump_ready = 1'b0;
      drive(2'b01, 2'b00, 64'h200, 64'h0, 64'h7, 64'h0);
      to_pos(); idle_in(); rpc = 'x; rwd = 64'h7;
      exp_err.push_back(x_code);
      to_pos(); rpc = '0;
      @(negedge clk);
      check("t7_code", {61'd0, err_code}, {61'd0, x_code});
      check("t7_dump_valid", {63'd0, dump_valid}, 64'd1);
      #1 arst_i = 1'b0; #1;
      check("t7_rst_err", {63'd0, err}, 64'd0);
      check("t7_rst_dump_valid", {63'd0, dump_valid}, 64'd0);
      check("t7_rst_dump_last", {63'd0, dump_last}, 64'd0);
      check("t7_rst_done", {63'd0, done}, 64'd0);
      @(posedge clk); #2 arst_i = 1'b1;
      to_pos(); dump_ready = 1'b1;
      drive(2'b01, 2'b00, 64'h500, 64'h0, 64'h0, 64'h0);
      @(negedge clk);
      check("t7_run_step", {63'd0, step_valid}, 64'd1);
      check("t7_run_done", {63'd0, done}, 64'd0);
      to_pos(); idle_in();
      to_pos();

      check("left_err", 64'(exp_err.size()), 64'd0);
      check("left_dump", 64'(exp_dump.size()), 64'd0);
      check("left_done", 64'(exp_done.size()), 64'd0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
